// File: rtl/module_serial_subtractor.sv
// Bit-serial subtractor: S = A - B (mod 2^ANCHO), LSB-first, one full-subtractor
// cell plus a borrow flop, with valid/ready handshakes on both operand and result sides.
module module_serial_subtractor #(
    parameter int ANCHO = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [ANCHO-1:0] A_i,
    input  logic [ANCHO-1:0] B_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [ANCHO-1:0] S_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(ANCHO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANCHO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [ANCHO-1:0]  a_sr_r;
    logic [ANCHO-1:0]  b_sr_r;
    logic [ANCHO-1:0]  result_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              borrow_r;
    logic              a_msb_r;
    logic              b_msb_r;
    logic              overflow_r;
    logic [1:0]        fs_s;
    logic              accept_s;
    logic              last_bit_s;

    assign fs_s       = full_sub(a_sr_r[0], b_sr_r[0], borrow_r);
    assign accept_s   = valid_i && (state_r == ST_IDLE);
    assign last_bit_s = (state_r == ST_RUN) && (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: operand shift registers, result register, borrow flop, counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_sr_r     <= {ANCHO{1'b0}};
            b_sr_r     <= {ANCHO{1'b0}};
            result_r   <= {ANCHO{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            borrow_r   <= 1'b0;
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            a_sr_r     <= A_i;
            b_sr_r     <= B_i;
            result_r   <= {ANCHO{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            borrow_r   <= 1'b0;
            a_msb_r    <= A_i[ANCHO-1];
            b_msb_r    <= B_i[ANCHO-1];
            overflow_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            // New difference bit enters at the MSB so the LSB ends up at bit 0.
            result_r <= {fs_s[0], result_r[ANCHO-1:1]};
            a_sr_r   <= {1'b0, a_sr_r[ANCHO-1:1]};
            b_sr_r   <= {1'b0, b_sr_r[ANCHO-1:1]};
            borrow_r <= fs_s[1];
            if (last_bit_s) begin
                cnt_r      <= cnt_r;
                overflow_r <= (a_msb_r != b_msb_r) && (fs_s[0] != a_msb_r);
            end else begin
                cnt_r      <= cnt_r + CNT_W'(1);
                overflow_r <= overflow_r;
            end
        end else begin
            a_sr_r     <= a_sr_r;
            b_sr_r     <= b_sr_r;
            result_r   <= result_r;
            cnt_r      <= cnt_r;
            borrow_r   <= borrow_r;
            a_msb_r    <= a_msb_r;
            b_msb_r    <= b_msb_r;
            overflow_r <= overflow_r;
        end
    end

    assign ready_o    = (state_r == ST_IDLE);
    assign valid_o    = (state_r == ST_DONE);
    assign S_o        = result_r;
    assign borrow_o   = borrow_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_module_serial_subtractor.sv
// Directed/table-driven bench for module_serial_subtractor (ANCHO=8 main, ANCHO=4 sweep).
module tb_module_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       valid_i, ready_i;
    logic [7:0] A_i, B_i;
    logic       ready_o, valid_o, borrow_o, overflow_o;
    logic [7:0] S_o;

    logic       valid4, ready4;
    logic [3:0] A4, B4;
    logic       ready4_o, valid4_o, borrow4_o, overflow4_o;
    logic [3:0] S4_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_hs = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_serial_subtractor #(.ANCHO(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .A_i(A_i), .B_i(B_i), .valid_o(valid_o), .ready_i(ready_i),
        .S_o(S_o), .borrow_o(borrow_o), .overflow_o(overflow_o)
    );

    module_serial_subtractor #(.ANCHO(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid4), .ready_o(ready4_o),
        .A_i(A4), .B_i(B4), .valid_o(valid4_o), .ready_i(ready4),
        .S_o(S4_o), .borrow_o(borrow4_o), .overflow_o(overflow4_o)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       bw;
        logic       ov;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one operation from a negedge with ready_i=1; returns at the negedge after the handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit check_gap,
                          output logic [7:0] s, output logic bw, output logic ov);
        int lat;
        chk("ready_before_accept", ready_o, 1'b1);
        valid_i = 1'b1; A_i = a; B_i = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        A_i = 8'($urandom_range(0, 255));
        B_i = 8'($urandom_range(0, 255));
        lat = 0;
        while (!valid_o && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 8);
        s = S_o; bw = borrow_o; ov = overflow_o;
        @(posedge clk);
        if (check_gap && last_hs >= 0) chk("handshake_gap", cyc - last_hs, 10);
        last_hs = cyc;
        @(negedge clk);
        chk("valid_after_hs", valid_o, 1'b0);
    endtask

    initial begin
        logic [7:0] s, ea, eb, es;
        logic       bw, ov, eov;
        int         sd, lat;

        vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3]  = '{8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0};
        vecs[4]  = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[5]  = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[6]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[7]  = '{8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[9]  = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        vecs[10] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};

        rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; A_i = 8'h00; B_i = 8'h00;
        valid4 = 1'b0; ready4 = 1'b1; A4 = 4'h0; B4 = 4'h0;
        #3;
        chk("reset_ready", ready_o, 1'b1);
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_S", S_o, 8'h00);
        chk("reset_borrow", borrow_o, 1'b0);
        chk("reset_ovf", overflow_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, s, bw, ov);
            chk($sformatf("vec%0d_S", i), s, vecs[i].s);
            chk($sformatf("vec%0d_borrow", i), bw, vecs[i].bw);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
        end

        // Backpressure: hold ready_i low for 5 cycles in DONE, with an ignored valid_i pulse.
        ready_i = 1'b0;
        valid_i = 1'b1; A_i = 8'h3C; B_i = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            chk("bp_S", S_o, 8'h2D);
            chk("bp_valid", valid_o, 1'b1);
            chk("bp_ready", ready_o, 1'b0);
            if (k == 1) begin
                valid_i = 1'b1; A_i = 8'hFF; B_i = 8'h00;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        chk("bp_S_end", S_o, 8'h2D);
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", ready_o, 1'b1);
        chk("bp_valid_drop", valid_o, 1'b0);
        chk("bp_S_held", S_o, 8'h2D);

        // Reset in the middle of RUN.
        valid_i = 1'b1; A_i = 8'hAA; B_i = 8'h55;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_S", S_o, 8'h00);
        chk("mid_rst_ready", ready_o, 1'b1);
        chk("mid_rst_borrow", borrow_o, 1'b0);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        run_op(8'h10, 8'h20, 1'b0, s, bw, ov);
        chk("post_rst_S", s, 8'hF0);
        chk("post_rst_borrow", bw, 1'b1);

        // Back-to-back sweep against an arithmetic reference.
        last_hs = -1;
        for (int k = 0; k < 1000; k++) begin
            ea = 8'($urandom_range(0, 255));
            eb = (k % 4 == 0) ? ea : 8'($urandom_range(0, 255));
            run_op(ea, eb, 1'b1, s, bw, ov);
            es  = ea - eb;
            sd  = int'($signed(ea)) - int'($signed(eb));
            eov = (sd > 127) || (sd < -128);
            chk("sweep_S", s, es);
            chk("sweep_borrow", bw, (ea < eb));
            chk("sweep_ovf", ov, eov);
        end

        // ANCHO=4 instance.
        for (int k = 0; k < 200; k++) begin
            logic [3:0] a4, b4, e4;
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            valid4 = 1'b1; A4 = a4; B4 = b4;
            @(posedge clk);
            @(negedge clk);
            valid4 = 1'b0;
            lat = 0;
            while (!valid4_o && lat < 40) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            chk("w4_latency", lat, 4);
            e4 = a4 - b4;
            sd = int'($signed(a4)) - int'($signed(b4));
            chk("w4_S", S4_o, e4);
            chk("w4_borrow", borrow4_o, (a4 < b4));
            chk("w4_ovf", overflow4_o, ((sd > 7) || (sd < -8)));
            @(posedge clk);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
